// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Serial back end of the debug-unit print path. Bytes arrive from the print
// stage over a valid/ready handshake. They are buffered in a small FIFO and
// sent on txd as 8N1 UART frames, LSB first.
//
// Ports
//   clk_tx      in   transmit clock
//   rst         in   asynchronous reset, active-high
//   vld_tx      in   d_tx holds a valid byte
//   d_tx        in   byte to send (8 bits)
//   rdy_tx      out  FIFO can accept a byte (= not full)
//   txd         out  UART serial line, idle high, registered
//   busy        out  frame in progress or FIFO non-empty
//   fifo_level  out  current FIFO occupancy ($clog2(FIFO_DEPTH)+1 bits)
//   dbg_state   out  FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: a byte transfers on every rising clk_tx edge where vld_tx and
// rdy_tx are both high. rdy_tx depends only on registered occupancy, so it
// never depends on vld_tx in the same cycle. When rdy_tx is low, vld_tx is
// ignored. The producer must then hold d_tx stable until the transfer happens.
module uart_tx_engine #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_tx,
  input  logic                        rst,
  input  logic                        vld_tx,
  input  logic [7:0]                  d_tx,
  output logic                        rdy_tx,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [1:0]                  dbg_state
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [7:0]       w_head;

  // FSM / shifter state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_txd;
  logic             w_txd_d;
  logic             w_bit_end;

  // Full/empty come from the occupancy count, never from pointer compare.
  assign w_empty = (r_level == '0);
  assign rdy_tx  = (r_level != LVL_W'(FIFO_DEPTH));
  assign w_push  = vld_tx & rdy_tx;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_tx) begin
    if (w_push) r_mem[r_wr_ptr] <= d_tx;
  end

  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_bit_end = (r_cnt == CNT_W'(DIV - 1));

  // Next-state logic. w_txd_d is the line level for the current state. It is
  // registered into r_txd, so txd lags the state by one cycle. Every state
  // still lasts exactly DIV cycles, so each bit period stays exact.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_d       = 1'b1;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_txd_d   = 1'b0;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        w_txd_d   = r_shift[0];
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_txd_d   = 1'b1;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_d;
    end
  end

  assign txd        = r_txd;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign fifo_level = r_level;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic       clk_tx = 1'b0;
  logic       rst;
  logic       vld_tx;
  logic [7:0] d_tx;
  logic       rdy_tx;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_acc    = 0;
  int frame_err   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  uart_tx_engine #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_tx    (clk_tx),
    .rst       (rst),
    .vld_tx    (vld_tx),
    .d_tx      (d_tx),
    .rdy_tx    (rdy_tx),
    .txd       (txd),
    .busy      (busy),
    .fifo_level(fifo_level),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk_tx = ~clk_tx;
  always @(posedge clk_tx) cyc <= cyc + 1;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Ideal 8N1 line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0)      return 1'b0;
    else if (k <= 8) return b[k-1];
    else             return 1'b1;
  endfunction

  // Line decoder: a start is the first low sample. Each bit is then read at
  // the middle of its period.
  always begin : rx_monitor
    logic [7:0] b;
    int         st;
    @(negedge clk_tx);
    if (txd === 1'b0) begin
      st = cyc;
      repeat (DIV / 2) @(negedge clk_tx);
      if (txd !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk_tx);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk_tx);
      if (txd !== 1'b1) frame_err++;
      rx_q.push_back(b);
      rx_start_q.push_back(st);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_tx);
  endtask

  // Called on a negedge. Returns on the negedge after the accepting edge and
  // leaves vld_tx high. last_acc holds the index of the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int t;
    t      = 0;
    vld_tx = 1'b1;
    d_tx   = b;
    while (rdy_tx !== 1'b1 && t < 2000) begin
      @(negedge clk_tx);
      t++;
    end
    if (t >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: byte %02h never accepted", b);
      vld_tx = 1'b0;
    end else begin
      @(negedge clk_tx);
      last_acc = cyc;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk_tx);
      t++;
    end
    vectors++;
    if (rx_q.size() < n) begin
      miscompares++;
      $display("FAIL rx_count: got %0d frames, want %0d", rx_q.size(), n);
    end
  endtask

  // Scoreboard: decoded bytes against the expected queue, then clear.
  task automatic check_stream(input string name);
    vectors++;
    if (rx_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes, want %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %02h, want %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_err !== 0) begin
      miscompares++;
      $display("FAIL %s_framing: got %0d framing errors, want 0", name, frame_err);
    end
    rx_q.delete();
    exp_q.delete();
    rx_start_q.delete();
    frame_err = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lows;
    rst    = 1'b1;
    vld_tx = 1'b0;
    d_tx   = 8'h00;
    idle(3);
    vectors += 4;
    if (txd !== 1'b1)        begin miscompares++; $display("FAIL rst_txd: got %b, want 1", txd); end
    if (rdy_tx !== 1'b1)     begin miscompares++; $display("FAIL rst_rdy: got %b, want 1", rdy_tx); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy: got %b, want 0", busy); end
    if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rst_level: got %0d, want 0", fifo_level); end
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_tx);
      if (txd !== 1'b1) lows++;
    end
    vectors += 5;
    if (lows !== 0)          begin miscompares++; $display("FAIL idle_txd_low: got %0d low cycles, want 0", lows); end
    if (txd !== 1'b1)        begin miscompares++; $display("FAIL idle_txd: got %b, want 1", txd); end
    if (rdy_tx !== 1'b1)     begin miscompares++; $display("FAIL idle_rdy: got %b, want 1", rdy_tx); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL idle_busy: got %b, want 0", busy); end
    if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL idle_level: got %0d, want 0", fifo_level); end
  endtask

  task automatic test_single(input logic [7:0] b);
    int bad;
    int first_bad;
    logic e;
    idle(2);
    push_byte(b);
    vld_tx = 1'b0;
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL single_lat0: got %b, want 1", txd); end
    idle(1);
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL single_lat1: got %b, want 1", txd); end
    idle(1);
    vectors += 2;
    if (txd !== 1'b0)  begin miscompares++; $display("FAIL single_lat2: got %b, want 0", txd); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, want 1", busy); end
    bad       = 0;
    first_bad = -1;
    for (int o = 0; o < FRAME; o++) begin
      if (o > 0) @(negedge clk_tx);
      e = frame_bit(b, o / DIV);
      if (txd !== e) begin
        bad++;
        if (first_bad < 0) first_bad = o;
      end
      if (o % DIV == DIV / 2) begin
        vectors++;
        if (txd !== e) begin
          miscompares++;
          $display("FAIL single_bit%0d (byte %02h): got %b, want %b", o / DIV, b, txd, e);
        end
      end
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL single_timing (byte %02h): got %0d wrong cycles (first at %0d), want 0", b, bad, first_bad);
    end
    idle(1);
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL single_after: got %b, want 1", txd); end
    idle(2);
    vectors += 2;
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL single_done_busy: got %b, want 0", busy); end
    if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL single_done_level: got %0d, want 0", fifo_level); end
    wait_rx(1, 2 * FRAME);
    check_stream("single");
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    idle(2);
    push_byte(b0);
    push_byte(b1);
    push_byte(b2);
    vld_tx = 1'b0;
    wait_rx(3, 4 * FRAME);
    if (rx_start_q.size() >= 3) begin
      vectors += 2;
      if (rx_start_q[1] - rx_start_q[0] !== FRAME) begin
        miscompares++;
        $display("FAIL b2b_gap01: got %0d cycles, want %0d", rx_start_q[1] - rx_start_q[0], FRAME);
      end
      if (rx_start_q[2] - rx_start_q[1] !== FRAME) begin
        miscompares++;
        $display("FAIL b2b_gap12: got %0d cycles, want %0d", rx_start_q[2] - rx_start_q[1], FRAME);
      end
    end
    idle(DIV);
    check_stream("b2b");
  endtask

  task automatic test_fifo_full();
    int p;
    idle(2);
    push_byte(8'($urandom_range(0, 255)));
    p = last_acc;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    d_tx = 8'h05;
    vectors += 2;
    if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_level: got %0d, want 4", fifo_level); end
    if (rdy_tx !== 1'b0)     begin miscompares++; $display("FAIL full_rdy: got %b, want 0", rdy_tx); end
    push_byte(8'h05);
    vld_tx = 1'b0;
    // First pop is at the end of the leading frame: edge p+1+FRAME.
    // rdy_tx reflects it one cycle later, so byte 5 enters at p+FRAME+2.
    vectors++;
    if (last_acc - p !== FRAME + 2) begin
      miscompares++;
      $display("FAIL full_accept: got edge +%0d, want +%0d", last_acc - p, FRAME + 2);
    end
    wait_rx(6, 7 * FRAME);
    idle(DIV);
    check_stream("full");
  endtask

  task automatic test_push_pop();
    int p;
    logic [7:0] y;
    idle(2);
    push_byte(8'($urandom_range(0, 255)));
    p = last_acc;
    push_byte(8'($urandom_range(0, 255)));
    vld_tx = 1'b0;
    idle(p + FRAME - cyc);
    vectors++;
    if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL pp_level_before: got %0d, want 1", fifo_level); end
    y      = 8'($urandom_range(0, 255));
    vld_tx = 1'b1;
    d_tx   = y;
    @(negedge clk_tx);
    exp_q.push_back(y);
    vld_tx = 1'b0;
    vectors += 2;
    if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL pp_level_after: got %0d, want 1", fifo_level); end
    if (rdy_tx !== 1'b1)     begin miscompares++; $display("FAIL pp_rdy: got %b, want 1", rdy_tx); end
    wait_rx(3, 4 * FRAME);
    if (rx_start_q.size() >= 3) begin
      vectors++;
      if (rx_start_q[2] - rx_start_q[0] !== 2 * FRAME) begin
        miscompares++;
        $display("FAIL pp_contig: got %0d cycles, want %0d", rx_start_q[2] - rx_start_q[0], 2 * FRAME);
      end
    end
    idle(DIV);
    check_stream("pushpop");
  endtask

  task automatic test_reset_midframe();
    int p;
    int lows;
    idle(2);
    push_byte(8'hC3);
    p = last_acc;
    push_byte(8'($urandom_range(0, 255)));
    vld_tx = 1'b0;
    idle(p + 2 + 70 - cyc);
    vectors++;
    if (txd !== frame_bit(8'hC3, 70 / DIV)) begin
      miscompares++;
      $display("FAIL midrst_pre: got %b, want %b", txd, frame_bit(8'hC3, 70 / DIV));
    end
    rst = 1'b1;
    #1;
    vectors += 4;
    if (txd !== 1'b1)        begin miscompares++; $display("FAIL midrst_txd: got %b, want 1", txd); end
    if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL midrst_level: got %0d, want 0", fifo_level); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL midrst_busy: got %b, want 0", busy); end
    if (rdy_tx !== 1'b1)     begin miscompares++; $display("FAIL midrst_rdy: got %b, want 1", rdy_tx); end
    @(negedge clk_tx);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk_tx);
      if (txd !== 1'b1) lows++;
    end
    vectors += 2;
    if (lows !== 0)    begin miscompares++; $display("FAIL midrst_quiet: got %0d low cycles, want 0", lows); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_busy: got %b, want 0", busy); end
    // The aborted frame is not part of the expected stream.
    rx_q.delete();
    exp_q.delete();
    rx_start_q.delete();
    frame_err = 0;
  endtask

  task automatic test_random_stream(input int n);
    int gaps_bad;
    idle(2);
    for (int i = 0; i < n; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      vld_tx = 1'b0;
      idle($urandom_range(0, 2 * FRAME));
    end
    wait_rx(n, (n + 2) * FRAME);
    gaps_bad = 0;
    for (int i = 1; i < rx_start_q.size(); i++) begin
      if (rx_start_q[i] - rx_start_q[i-1] < FRAME) gaps_bad++;
    end
    vectors++;
    if (gaps_bad !== 0) begin miscompares++; $display("FAIL rand_spacing: got %0d short frames, want 0", gaps_bad); end
    idle(DIV);
    check_stream("rand");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst    = 1'b1;
    vld_tx = 1'b0;
    d_tx   = 8'h00;
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom_range(0, 255)));
    test_back_to_back(8'hA3, 8'h0F, 8'hFF);
    test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_fifo_full();
    test_push_pop();
    test_reset_midframe();
    test_random_stream(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
